// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// Includes the grant state encoding, the select constants and the idle-arbitration helper.
package mux_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // From IDLE: a lone requester wins; on a tie the pointer decides (ptr_b=1 favours B).
    function automatic state_e pick_owner(input logic a_valid,
                                          input logic b_valid,
                                          input logic ptr_b);
        state_e owner;
        owner = IDLE;
        if (a_valid && (!b_valid || !ptr_b)) begin
            owner = OWN_A;
        end else if (b_valid) begin
            owner = OWN_B;
        end
        return owner;
    endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// Scalable 2:1 data mux shared by the two streams.
// An unknown select merges bitwise through the conditional operator; after reset the select is always known.
module mux #(
    parameter int unsigned size = 8
) (
    input  logic [size-1:0] a_i,
    input  logic [size-1:0] b_i,
    input  logic            sel_i,
    output logic [size-1:0] out_o
);

    assign out_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin burst arbiter time-multiplexing streams A and B through one mux
// into a registered valid/ready output stage.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned size  = 8,
    parameter int unsigned BURST = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            A_VALID,
    input  logic [size-1:0] A_DATA,
    output logic            A_READY,
    input  logic            B_VALID,
    input  logic [size-1:0] B_DATA,
    output logic            B_READY,
    output logic            OUT_VALID,
    output logic [size-1:0] OUT_DATA,
    input  logic            OUT_READY,
    output logic            SEL
);

    localparam int unsigned CNT_W = $clog2(BURST + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_beat;
    logic              ptr_q, ptr_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    logic [size-1:0]   out_data_q, out_data_d;
    logic [size-1:0]   mux_out;
    logic              en;
    logic              a_xfer;
    logic              b_xfer;

    assign en        = !out_valid_q || OUT_READY;
    assign A_READY   = (state_q == OWN_A) && en;
    assign B_READY   = (state_q == OWN_B) && en;
    assign a_xfer    = A_VALID && A_READY;
    assign b_xfer    = B_VALID && B_READY;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_beat = (cnt_inc == CNT_W'(BURST));

    mux #(
        .size (size)
    ) u_mux (
        .a_i   (A_DATA),
        .b_i   (B_DATA),
        .sel_i (sel_q),
        .out_o (mux_out)
    );

    // Grant FSM: burst counting, owner drop handling, pointer and select tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;

        unique case (state_q)
            IDLE: begin
                state_d = pick_owner(A_VALID, B_VALID, ptr_q);
            end
            OWN_A: begin
                if (!A_VALID) begin
                    cnt_d   = '0;
                    state_d = B_VALID ? OWN_B : IDLE;
                end else if (en) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        if (B_VALID) begin
                            state_d = OWN_B;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            OWN_B: begin
                if (!B_VALID) begin
                    cnt_d   = '0;
                    state_d = A_VALID ? OWN_A : IDLE;
                end else if (en) begin
                    if (last_beat) begin
                        cnt_d = '0;
                        if (A_VALID) begin
                            state_d = OWN_A;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A new grant points the next tie at the side that was not just granted.
        if ((state_d != state_q) && (state_d != IDLE)) begin
            ptr_d = (state_d == OWN_A);
        end

        case (state_d)
            OWN_A:   sel_d = SEL_A;
            OWN_B:   sel_d = SEL_B;
            default: sel_d = sel_q;
        endcase
    end

    // Output stage: load on transfer, drain when the consumer takes the beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (a_xfer || b_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_out;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            sel_q       <= SEL_A;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign SEL       = sel_q;

endmodule
